// File: rtl/multiply_acc_array_pkg.sv
// Shared helpers for the multi-lane multiply-accumulate datapath:
// width derivation and signed saturation reused by pooling and bias blocks.
package multiply_acc_array_pkg;

    localparam int SAT_MAX_W = 128;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int acc_width(
        input int iw,
        input int kw,
        input int lanes,
        input int guard
    );
        return iw + kw + clog2(lanes) + guard;
    endfunction

    // Clamp a sign-extended value into a signed range of the given width.
    function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
        input logic signed [SAT_MAX_W-1:0] value,
        input int                          width
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = SAT_MAX_W'(1) << (width - 1);
        hi = hi - SAT_MAX_W'(1);
        lo = ~hi;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/multiply_acc_array_adder_tree.sv
// Registered signed reduction tree, one level per stage; the
// valid/first/last sideband is delayed to stay aligned with the sum.
module mac_adder_tree
    import multiply_acc_array_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [LANES*WIDTH-1:0]                data,
    input  logic [2:0]                            flags_in,
    output logic signed [WIDTH+clog2(LANES)-1:0]  sum,
    output logic [2:0]                            flags_out
);

    localparam int TREE = clog2(LANES);

    for (genvar l = 0; l <= TREE; l++) begin : lvl
        localparam int N = LANES >> l;
        localparam int W = WIDTH + l;
        logic signed [W-1:0] node [N];

        if (l == 0) begin : g_leaf
            // Unpack the flat lane bus into signed leaves.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    node[i] = signed'(data[i*WIDTH +: WIDTH]);
                end
            end
        end else begin : g_sum
            // Pairwise add of the previous level, widened by one bit.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int j = 0; j < N; j++) node[j] <= '0;
                end else begin
                    for (int j = 0; j < N; j++) begin
                        node[j] <= W'(lvl[l-1].node[2*j])
                                 + W'(lvl[l-1].node[2*j+1]);
                    end
                end
            end
        end
    end

    assign sum = lvl[TREE].node[0];

    if (TREE == 0) begin : g_nodly
        assign flags_out = flags_in;
    end else begin : g_dly
        logic [2:0] pipe [TREE];

        // Sideband shift register matching the tree depth.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < TREE; k++) pipe[k] <= '0;
            end else begin
                pipe[0] <= flags_in;
                for (int k = 1; k < TREE; k++) pipe[k] <= pipe[k-1];
            end
        end

        assign flags_out = pipe[TREE-1];
    end

endmodule

// File: rtl/multiply_acc_array.sv
// Multi-lane signed MAC: input regs, products, adder tree, grouped
// accumulator and a saturating (or wrapping) output register.
module multiply_acc_array
    import multiply_acc_array_pkg::*;
#(
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int LANES     = 4,
    parameter int GUARD     = 8,
    parameter int OUT_WIDTH = 32,
    parameter int SATURATE  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES*IMG_WIDTH-1:0]   img,
    input  logic [LANES*KER_WIDTH-1:0]   ker,
    input  logic                         val,
    input  logic                         first,
    input  logic                         last,
    output logic [OUT_WIDTH-1:0]         result,
    output logic                         result_val,
    output logic                         overflow
);

    localparam int TREE      = clog2(LANES);
    localparam int ACC_WIDTH = acc_width(IMG_WIDTH, KER_WIDTH, LANES, GUARD);
    localparam int PW        = IMG_WIDTH + KER_WIDTH;
    localparam int SW        = PW + TREE;

    logic [LANES*IMG_WIDTH-1:0] img_q;
    logic [LANES*KER_WIDTH-1:0] ker_q;
    logic                       val_q;
    logic                       first_q;
    logic                       last_q;

    logic [LANES*PW-1:0]        prod_d;
    logic [LANES*PW-1:0]        prod_q;
    logic [2:0]                 flags_p2;

    logic signed [SW-1:0]       tree_sum;
    logic [2:0]                 flags_t;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic                        acc_last;

    logic signed [SAT_MAX_W-1:0] wide;
    logic signed [SAT_MAX_W-1:0] clamp;
    logic [OUT_WIDTH-1:0]        res_d;
    logic                        ovf_d;

    // Capture a beat; idle cycles inject zeros and clear the flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            img_q   <= '0;
            ker_q   <= '0;
            val_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (val) begin
            img_q   <= img;
            ker_q   <= ker;
            val_q   <= 1'b1;
            first_q <= first;
            last_q  <= last;
        end else begin
            img_q   <= '0;
            ker_q   <= '0;
            val_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    // Full-width signed product per lane.
    always_comb begin
        prod_d = '0;
        for (int l = 0; l < LANES; l++) begin
            prod_d[l*PW +: PW] =
                PW'(signed'(img_q[l*IMG_WIDTH +: IMG_WIDTH]))
              * PW'(signed'(ker_q[l*KER_WIDTH +: KER_WIDTH]));
        end
    end

    // Product register with its sideband.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q   <= '0;
            flags_p2 <= '0;
        end else begin
            prod_q   <= prod_d;
            flags_p2 <= {val_q, first_q, last_q};
        end
    end

    mac_adder_tree #(
        .WIDTH (PW),
        .LANES (LANES)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .data      (prod_q),
        .flags_in  (flags_p2),
        .sum       (tree_sum),
        .flags_out (flags_t)
    );

    // Next accumulator: restart on first, add on valid, else hold.
    always_comb begin
        acc_d = acc;
        if (flags_t[1]) begin
            acc_d = ACC_WIDTH'(tree_sum);
        end else if (flags_t[2]) begin
            acc_d = acc + ACC_WIDTH'(tree_sum);
        end
    end

    // Accumulator register; last travels one stage behind the sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            acc_last <= 1'b0;
        end else begin
            acc      <= acc_d;
            acc_last <= flags_t[0];
        end
    end

    // Narrow the post-update accumulator to the result width.
    always_comb begin
        wide  = SAT_MAX_W'(acc);
        clamp = sat_signed(wide, OUT_WIDTH);
        if (SATURATE != 0) begin
            res_d = clamp[OUT_WIDTH-1:0];
            ovf_d = (clamp != wide);
        end else begin
            res_d = acc[OUT_WIDTH-1:0];
            ovf_d = 1'b0;
        end
    end

    // Result holds between strobes; valid and overflow pulse together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result     <= '0;
            result_val <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            result_val <= acc_last;
            overflow   <= acc_last & ovf_d;
            if (acc_last) result <= res_d;
        end
    end

endmodule

// File: tb/tb_multiply_acc_array.sv
// Directed bench for multiply_acc_array: default, 16-bit saturating,
// 16-bit wrapping and single-lane builds share one stimulus bus.
module tb_multiply_acc_array;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] img = '0;
    logic [63:0] ker = '0;
    logic        val = 1'b0;
    logic        first = 1'b0;
    logic        last = 1'b0;

    logic [31:0] r_main;
    logic        rv_main;
    logic        ov_main;
    logic [15:0] r_sat;
    logic        rv_sat;
    logic        ov_sat;
    logic [15:0] r_wrap;
    logic        rv_wrap;
    logic        ov_wrap;
    logic [31:0] r_one;
    logic        rv_one;
    logic        ov_one;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    int          q_at  [$];
    logic [31:0] q_res [$];
    logic        q_ov  [$];
    int          n_sat, n_wrap, n_one, at_one;
    logic [15:0] s_res, w_res;
    logic        s_ov, w_ov;
    logic [31:0] o_res;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    multiply_acc_array u_main (
        .clk(clk), .rst(rst), .img(img), .ker(ker),
        .val(val), .first(first), .last(last),
        .result(r_main), .result_val(rv_main), .overflow(ov_main)
    );

    multiply_acc_array #(.OUT_WIDTH(16), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .img(img), .ker(ker),
        .val(val), .first(first), .last(last),
        .result(r_sat), .result_val(rv_sat), .overflow(ov_sat)
    );

    multiply_acc_array #(.OUT_WIDTH(16), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .img(img), .ker(ker),
        .val(val), .first(first), .last(last),
        .result(r_wrap), .result_val(rv_wrap), .overflow(ov_wrap)
    );

    multiply_acc_array #(.LANES(1)) u_one (
        .clk(clk), .rst(rst), .img(img[15:0]), .ker(ker[15:0]),
        .val(val), .first(first), .last(last),
        .result(r_one), .result_val(rv_one), .overflow(ov_one)
    );

    // Log every strobe away from the active edge.
    always @(negedge clk) begin
        if (rv_main) begin
            q_at.push_back(cyc);
            q_res.push_back(r_main);
            q_ov.push_back(ov_main);
        end
        if (rv_sat) begin
            n_sat++;
            s_res = r_sat;
            s_ov  = ov_sat;
        end
        if (rv_wrap) begin
            n_wrap++;
            w_res = r_wrap;
            w_ov  = ov_wrap;
        end
        if (rv_one) begin
            n_one++;
            at_one = cyc;
            o_res  = r_one;
        end
    end

    function automatic logic [63:0] pack4(
        input logic [15:0] a, input logic [15:0] b,
        input logic [15:0] c, input logic [15:0] d
    );
        return {d, c, b, a};
    endfunction

    task automatic clear_mon();
        q_at.delete();
        q_res.delete();
        q_ov.delete();
        n_sat = 0; n_wrap = 0; n_one = 0; at_one = -1;
        s_res = '0; w_res = '0; o_res = '0;
        s_ov = 1'b0; w_ov = 1'b0;
    endtask

    task automatic drive(
        input logic v, input logic f, input logic l,
        input logic [63:0] i, input logic [63:0] k,
        output int at
    );
        @(negedge clk);
        val = v; first = f; last = l; img = i; ker = k;
        at = cyc;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            val = 1'b0; first = 1'b0; last = 1'b0;
            img = '0; ker = '0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (r_main !== 32'd0) begin
            fails++;
            $display("FAIL reset_result: got %0h want 0", r_main);
        end
        checks++;
        if (rv_main !== 1'b0 || ov_main !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b%b want 00", rv_main, ov_main);
        end
        checks++;
        if (r_one !== 32'd0 || r_sat !== 16'd0) begin
            fails++;
            $display("FAIL reset_other: got %0h/%0h want 0/0", r_one, r_sat);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_single_beat();
        int t;
        clear_mon();
        drive(1, 1, 1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), t);
        idle(10);
        checks++;
        if (q_at.size() !== 1) begin
            fails++;
            $display("FAIL single_count: got %0d want 1", q_at.size());
        end else begin
            checks++;
            if (q_res[0] !== 32'd70) begin
                fails++;
                $display("FAIL single_result: got %0d want 70", q_res[0]);
            end
            checks++;
            if (q_at[0] !== t + 6) begin
                fails++;
                $display("FAIL single_latency: got %0d want %0d", q_at[0] - t, 6);
            end
            checks++;
            if (q_ov[0] !== 1'b0) begin
                fails++;
                $display("FAIL single_ovf: got %b want 0", q_ov[0]);
            end
        end
    endtask

    task automatic test_gaps();
        int t;
        logic [63:0] i3, k2;
        i3 = pack4(-16'sd3, -16'sd3, -16'sd3, -16'sd3);
        k2 = pack4(16'd2, 16'd2, 16'd2, 16'd2);
        clear_mon();
        drive(1, 1, 0, i3, k2, t);
        idle(2);
        drive(1, 0, 0, i3, k2, t);
        idle(1);
        drive(1, 0, 1, i3, k2, t);
        idle(12);
        checks++;
        if (q_at.size() !== 1) begin
            fails++;
            $display("FAIL gaps_count: got %0d want 1", q_at.size());
        end else begin
            checks++;
            if (q_res[0] !== 32'hFFFF_FFB8) begin
                fails++;
                $display("FAIL gaps_result: got %0h want ffffffb8", q_res[0]);
            end
            checks++;
            if (q_at[0] !== t + 6) begin
                fails++;
                $display("FAIL gaps_latency: got %0d want 6", q_at[0] - t);
            end
        end
        checks++;
        if (r_main !== 32'hFFFF_FFB8) begin
            fails++;
            $display("FAIL gaps_hold: got %0h want ffffffb8", r_main);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        logic [63:0] ones;
        ones = pack4(16'd1, 16'd1, 16'd1, 16'd1);
        clear_mon();
        drive(1, 1, 0, ones, ones, t);
        drive(1, 0, 1, ones, ones, t);
        drive(1, 1, 1, ones, ones, t);
        idle(10);
        checks++;
        if (q_at.size() !== 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d want 2", q_at.size());
        end else begin
            checks++;
            if (q_res[0] !== 32'd8 || q_res[1] !== 32'd4) begin
                fails++;
                $display("FAIL b2b_results: got %0d,%0d want 8,4",
                         q_res[0], q_res[1]);
            end
            checks++;
            if (q_at[1] !== q_at[0] + 1 || q_at[1] !== t + 6) begin
                fails++;
                $display("FAIL b2b_timing: got %0d,%0d want %0d,%0d",
                         q_at[0], q_at[1], t + 5, t + 6);
            end
        end
    endtask

    task automatic test_saturate();
        int t;
        logic [63:0] mx;
        mx = pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        clear_mon();
        drive(1, 1, 1, mx, mx, t);
        idle(10);
        checks++;
        if (n_sat !== 1 || s_res !== 16'h7FFF || s_ov !== 1'b1) begin
            fails++;
            $display("FAIL sat16: got n=%0d %0h ov=%b want n=1 7fff ov=1",
                     n_sat, s_res, s_ov);
        end
        checks++;
        if (n_wrap !== 1 || w_res !== 16'h0004 || w_ov !== 1'b0) begin
            fails++;
            $display("FAIL wrap16: got n=%0d %0h ov=%b want n=1 0004 ov=0",
                     n_wrap, w_res, w_ov);
        end
        checks++;
        if (q_at.size() !== 1) begin
            fails++;
            $display("FAIL sat32_count: got %0d want 1", q_at.size());
        end else begin
            checks++;
            if (q_res[0] !== 32'h7FFF_FFFF || q_ov[0] !== 1'b1) begin
                fails++;
                $display("FAIL sat32: got %0h ov=%b want 7fffffff ov=1",
                         q_res[0], q_ov[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        logic [63:0] ones;
        ones = pack4(16'd1, 16'd1, 16'd1, 16'd1);
        drive(1, 1, 0, ones, ones, t);
        drive(1, 0, 1, ones, ones, t);
        idle(1);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (r_main !== 32'd0 || rv_main !== 1'b0 || ov_main !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got %0h %b %b want 0 0 0",
                     r_main, rv_main, ov_main);
        end
        checks++;
        if (r_sat !== 16'd0 || r_wrap !== 16'd0) begin
            fails++;
            $display("FAIL async_reset_narrow: got %0h %0h want 0 0",
                     r_sat, r_wrap);
        end
        clear_mon();
        idle(3);
        @(negedge clk);
        rst = 1'b1;
        idle(12);
        checks++;
        if (q_at.size() !== 0) begin
            fails++;
            $display("FAIL reset_no_strobe: got %0d want 0", q_at.size());
        end
        clear_mon();
        drive(1, 1, 1, ones, ones, t);
        idle(10);
        checks++;
        if (q_at.size() !== 1 || q_res[0] !== 32'd4) begin
            fails++;
            $display("FAIL after_reset: got n=%0d want n=1 result 4",
                     q_at.size());
        end
    endtask

    task automatic test_lanes1();
        int t;
        logic [63:0] neg;
        neg = pack4(16'h8000, 16'd0, 16'd0, 16'd0);
        clear_mon();
        drive(1, 1, 1, neg, neg, t);
        idle(10);
        checks++;
        if (n_one !== 1 || o_res !== 32'd1073741824) begin
            fails++;
            $display("FAIL lanes1_result: got n=%0d %0d want n=1 1073741824",
                     n_one, o_res);
        end
        checks++;
        if (at_one !== t + 4) begin
            fails++;
            $display("FAIL lanes1_latency: got %0d want 4", at_one - t);
        end
        checks++;
        if (q_at.size() !== 1 || q_res[0] !== 32'd1073741824) begin
            fails++;
            $display("FAIL lanes4_lane0: got n=%0d want n=1 1073741824",
                     q_at.size());
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single_beat();
        test_gaps();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        test_lanes1();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
